// File: rtl/spi_pkg.sv
// Shared types for the configurable SPI master: FSM states, per-transfer mode
// and a width helper used to size counters and selects.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LEAD,
    XFER,
    TRAIL
  } spi_state_t;

  typedef struct packed {
    logic cpol;
    logic cpha;
    logic lsb_first;
  } spi_mode_t;

  // Bits needed to index n items, never less than one.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// Half-period divider for the SPI serial clock: strobes each sclk edge one
// cycle before it becomes visible on the registered sclk output.
module spi_sclk_gen
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic idle_level,
  output logic tick,
  output logic lead_edge,
  output logic trail_edge,
  output logic sclk
);

  localparam int DIV_W = clog2_min1(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt_reg;
  logic             phase_reg;
  logic             sclk_reg;

  // phase_reg=0 means the next toggle is a leading edge.
  assign tick       = run && (div_cnt_reg == DIV_LAST);
  assign lead_edge  = tick && !phase_reg;
  assign trail_edge = tick && phase_reg;
  assign sclk       = sclk_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_reg <= '0;
      phase_reg   <= 1'b0;
      sclk_reg    <= 1'b0;
    end else if (!run) begin
      div_cnt_reg <= '0;
      phase_reg   <= 1'b0;
      sclk_reg    <= idle_level;
    end else if (tick) begin
      div_cnt_reg <= '0;
      phase_reg   <= ~phase_reg;
      sclk_reg    <= ~sclk_reg;
    end else begin
      div_cnt_reg <= div_cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/spi_master_cfg.sv
// SPI master with per-transfer mode, bit order and chip select, latched on
// accept; framed by CS setup (LEAD) and CS hold (TRAIL) periods.
module spi_master_cfg
  import spi_pkg::*;
#(
  parameter  int DATA_W  = 12,
  parameter  int CLK_DIV = 10,
  parameter  int NUM_CS  = 2,
  localparam int CS_W    = clog2_min1(NUM_CS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [DATA_W-1:0] tx_data,
  input  logic [CS_W-1:0]   cs_sel,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              lsb_first,
  output logic              sclk,
  output logic [NUM_CS-1:0] cs_n,
  output logic              mosi,
  input  logic              miso,
  output logic              rx_valid,
  output logic [DATA_W-1:0] rx_data,
  output logic              busy
);

  localparam int CNT_W  = clog2_min1(CLK_DIV);
  localparam int EDGE_W = clog2_min1(2 * DATA_W);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * DATA_W - 1);

  spi_state_t        state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [EDGE_W-1:0] edge_reg, edge_next;
  spi_mode_t         mode_reg;
  logic [CS_W-1:0]   sel_reg, sel_eff;
  logic [DATA_W-1:0] tx_shift_reg, tx_shift_next, tx_shifted;
  logic [DATA_W-1:0] rx_shift_reg, rx_shift_next;
  logic              mosi_reg, mosi_next;
  logic              rx_valid_reg, fire;
  logic [DATA_W-1:0] rx_data_reg;
  logic [NUM_CS-1:0] cs_n_reg, cs_n_next, cs_dec;
  logic              accept, tick, lead_edge, trail_edge;
  logic              sample, advance, out_bit;

  assign accept   = (state_reg == IDLE) && tx_valid && !rst;
  assign tx_ready = (state_reg == IDLE) && !rst;
  assign busy     = (state_reg != IDLE);
  assign cs_n     = cs_n_reg | {NUM_CS{rst}};
  assign rx_valid = rx_valid_reg && !rst;
  assign rx_data  = rx_data_reg;
  assign mosi     = mosi_reg;

  spi_sclk_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_sclk_gen (
    .clk       (clk),
    .rst       (rst),
    .run       (state_reg == XFER),
    .idle_level((state_reg == IDLE) ? cpol : mode_reg.cpol),
    .tick      (tick),
    .lead_edge (lead_edge),
    .trail_edge(trail_edge),
    .sclk      (sclk)
  );

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    edge_next  = edge_reg;
    case (state_reg)
      IDLE: begin
        cnt_next  = '0;
        edge_next = '0;
        if (tx_valid) state_next = LEAD;
      end
      LEAD: begin
        if (cnt_reg == CNT_LAST) begin
          state_next = XFER;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      XFER: begin
        if (tick) begin
          if (edge_reg == EDGE_LAST) begin
            state_next = TRAIL;
            cnt_next   = '0;
            edge_next  = '0;
          end else begin
            edge_next = edge_reg + 1'b1;
          end
        end
      end
      TRAIL: begin
        if (cnt_reg == CNT_LAST) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Registered one cycle ahead so the pulse lands on the last TRAIL cycle.
  assign fire = (state_next == TRAIL) && (cnt_next == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      edge_reg  <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      edge_reg  <= edge_next;
    end
  end

  assign sel_eff = accept ? cs_sel : sel_reg;

  generate
    for (genvar gi = 0; gi < NUM_CS; gi++) begin : g_cs_dec
      assign cs_dec[gi] = (sel_eff != CS_W'(gi));
    end
  endgenerate

  assign cs_n_next  = (state_next == IDLE) ? {NUM_CS{1'b1}} : cs_dec;
  assign out_bit    = mode_reg.lsb_first ? tx_shift_reg[0] : tx_shift_reg[DATA_W-1];
  assign tx_shifted = mode_reg.lsb_first ? (tx_shift_reg >> 1) : (tx_shift_reg << 1);
  assign sample     = mode_reg.cpha ? trail_edge : lead_edge;
  // cpha=0 presents the next bit after each trailing edge; the final one has none.
  assign advance    = mode_reg.cpha ? lead_edge : (trail_edge && (edge_reg != EDGE_LAST));

  always_comb begin
    tx_shift_next = tx_shift_reg;
    rx_shift_next = rx_shift_reg;
    mosi_next     = mosi_reg;
    if (accept) begin
      tx_shift_next = tx_data;
      mosi_next     = cpha ? 1'b0 : (lsb_first ? tx_data[0] : tx_data[DATA_W-1]);
    end else begin
      if (sample) begin
        rx_shift_next = mode_reg.lsb_first ? {miso, rx_shift_reg[DATA_W-1:1]}
                                           : {rx_shift_reg[DATA_W-2:0], miso};
      end
      if (advance) begin
        tx_shift_next = tx_shifted;
        mosi_next     = mode_reg.cpha ? out_bit
                      : (mode_reg.lsb_first ? tx_shifted[0] : tx_shifted[DATA_W-1]);
      end
      if ((state_next == TRAIL) || (state_next == IDLE)) mosi_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_reg     <= '0;
      sel_reg      <= '0;
      tx_shift_reg <= '0;
      rx_shift_reg <= '0;
      mosi_reg     <= 1'b0;
      rx_valid_reg <= 1'b0;
      rx_data_reg  <= '0;
      cs_n_reg     <= {NUM_CS{1'b1}};
    end else begin
      if (accept) begin
        mode_reg.cpol      <= cpol;
        mode_reg.cpha      <= cpha;
        mode_reg.lsb_first <= lsb_first;
        sel_reg            <= cs_sel;
      end
      tx_shift_reg <= tx_shift_next;
      rx_shift_reg <= rx_shift_next;
      mosi_reg     <= mosi_next;
      cs_n_reg     <= cs_n_next;
      rx_valid_reg <= fire;
      if (fire) rx_data_reg <= rx_shift_next;
    end
  end

endmodule
